// File: rtl/mor1kx_rf_spr_arbiter_cappuccino_pkg.sv
// Shared constants for the cappuccino GPR/SPR port arbiter: the SPR group
// that maps onto the GPR file and the arbiter FSM state encodings.
package mor1kx_rf_spr_arbiter_cappuccino_pkg;

  // SPR group 2 addresses the GPR file (all shadow banks included)
  localparam logic [6:0] SPR_GROUP_GPR = 7'h2;

  // Arbiter FSM state encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_RD_DATA = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // True when an SPR address falls in the GPR group
  function automatic logic is_gpr_group(input logic [15:0] addr);
    return addr[15:9] == SPR_GROUP_GPR;
  endfunction

endpackage

// File: rtl/mor1kx_rf_spr_arbiter_cappuccino_sat_counter.sv
// Saturating up-counter used to measure how long an SPR write has been
// held off by writeback. Clear has priority over increment; the at-limit
// flag comes straight from the count register so it is glitch free.
module mor1kx_sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_limit
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] r_count;

  // Count deferred cycles, stick at the limit, clear on demand
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIM)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_at_limit = (r_count == LIM);

endmodule

// File: rtl/mor1kx_rf_spr_arbiter_cappuccino.sv
// Arbiter for the cappuccino GPR RAM write port and SPR-side read port.
// Pipeline writeback always owns the write port; SPR-bus writes wait for a
// cycle without writeback. SPR reads issue only while the ctrl stage is not
// advancing and account for the 1-cycle RAM latency, with a bypass for a
// writeback to the same register. If writeback starves an SPR write for
// OPTION_MAX_DEFER cycles, spr_stall_o asks the pipeline to freeze.
//
// SPR handshake: spr_bus_stb_i is raised with address/we/data and held
// stable until spr_gpr_ack_o pulses for exactly one cycle; the master then
// drops stb. Dropping stb before ack aborts the access with no side effect.
// A new access is accepted only after stb has been seen low.
module mor1kx_rf_spr_arbiter_cappuccino
  import mor1kx_rf_spr_arbiter_cappuccino_pkg::*;
#(
  parameter int OPTION_RF_ADDR_WIDTH     = 5,
  parameter int OPTION_RF_NUM_SHADOW_GPR = 0,
  parameter int OPTION_OPERAND_WIDTH     = 32,
  parameter int OPTION_MAX_DEFER         = 8,
  localparam int RF_ADDR_WIDTH = OPTION_RF_ADDR_WIDTH + $clog2(OPTION_RF_NUM_SHADOW_GPR + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [15:0]                     spr_bus_addr_i,
  input  logic                            spr_bus_stb_i,
  input  logic                            spr_bus_we_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i,
  output logic                            spr_gpr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_o,
  input  logic                            padv_ctrl_i,
  input  logic                            wb_rf_wb_i,
  input  logic [RF_ADDR_WIDTH-1:0]        wb_rfd_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] result_i,
  output logic                            rf_wren_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rf_wrdat_o,
  output logic                            rf_re_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_rdad_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rf_rdat_i,
  output logic                            spr_stall_o
);

  localparam int         NUM_WORDS   = 32 * (OPTION_RF_NUM_SHADOW_GPR + 1);
  localparam logic [9:0] NUM_WORDS_L = 10'(NUM_WORDS);
  localparam int         CNT_W       = $clog2(OPTION_MAX_DEFER + 1);

  logic [2:0]                      r_state;
  logic [2:0]                      w_state_nxt;
  logic                            r_ack;
  logic [OPTION_OPERAND_WIDTH-1:0] r_dat;
  logic                            r_bypass;
  logic [OPTION_OPERAND_WIDTH-1:0] r_byp_dat;

  logic                     w_sel;
  logic                     w_oor;
  logic [RF_ADDR_WIDTH-1:0] w_idx;
  logic                     w_spr_wr;
  logic                     w_commit;
  logic                     w_defer;
  logic                     w_wb_hit;
  logic                     w_re;
  logic                     w_at_limit;

  assign w_sel = spr_bus_stb_i & is_gpr_group(spr_bus_addr_i);
  assign w_idx = spr_bus_addr_i[RF_ADDR_WIDTH-1:0];
  assign w_oor = ({1'b0, spr_bus_addr_i[8:0]} >= NUM_WORDS_L);

  // SPR write wants the port; never during reset so a reset cycle only
  // writes if writeback itself is writing.
  assign w_spr_wr = (r_state == ST_WR) & spr_bus_stb_i & ~rst;
  assign w_commit = w_spr_wr & ~wb_rf_wb_i;
  assign w_defer  = w_spr_wr & wb_rf_wb_i;
  assign w_wb_hit = wb_rf_wb_i & (wb_rfd_adr_i == w_idx);
  assign w_re     = (r_state == ST_RD_WAIT) & spr_bus_stb_i & ~padv_ctrl_i & ~rst;

  assign rf_re_o       = w_re;
  assign rf_rdad_o     = w_idx;
  assign spr_gpr_ack_o = r_ack;
  assign spr_gpr_dat_o = r_dat;
  assign spr_stall_o   = w_at_limit;

  // Write port mux: writeback first, then a pending SPR write
  always_comb begin
    rf_wren_o  = 1'b0;
    rf_wradr_o = wb_rfd_adr_i;
    rf_wrdat_o = result_i;
    if (wb_rf_wb_i) begin
      rf_wren_o = 1'b1;
    end else if (w_spr_wr) begin
      rf_wren_o  = 1'b1;
      rf_wradr_o = w_idx;
      rf_wrdat_o = spr_bus_dat_i;
    end
  end

  // Next-state logic; stb low in any busy state returns to IDLE (abort)
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_sel) begin
          if (w_oor)             w_state_nxt = ST_DONE;
          else if (spr_bus_we_i) w_state_nxt = ST_WR;
          else                   w_state_nxt = ST_RD_WAIT;
        end
      end
      ST_WR: begin
        if (!spr_bus_stb_i) w_state_nxt = ST_IDLE;
        else if (w_commit)  w_state_nxt = ST_DONE;
      end
      ST_RD_WAIT: begin
        if (!spr_bus_stb_i)   w_state_nxt = ST_IDLE;
        else if (w_re)        w_state_nxt = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (!spr_bus_stb_i) w_state_nxt = ST_IDLE;
        else                w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (!spr_bus_stb_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, ack pulse, read data and read-bypass registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_bypass  <= 1'b0;
      r_byp_dat <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sel && w_oor) begin
            r_ack <= 1'b1;
            r_dat <= '0;
          end
        end
        ST_WR: begin
          if (w_commit) r_ack <= 1'b1;
        end
        ST_RD_WAIT: begin
          // RAM returns pre-write data, so remember a same-cycle writeback
          if (w_re) begin
            r_bypass  <= w_wb_hit;
            r_byp_dat <= result_i;
          end
        end
        ST_RD_DATA: begin
          if (spr_bus_stb_i) begin
            r_ack <= 1'b1;
            if (w_wb_hit)      r_dat <= result_i;
            else if (r_bypass) r_dat <= r_byp_dat;
            else               r_dat <= rf_rdat_i;
          end
        end
        default: ;
      endcase
    end
  end

  mor1kx_sat_counter #(
    .WIDTH (CNT_W),
    .LIMIT (OPTION_MAX_DEFER)
  ) u_defer_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (~w_defer),
    .i_inc      (w_defer),
    .o_at_limit (w_at_limit)
  );

endmodule

// File: tb/tb_mor1kx_rf_spr_arbiter_cappuccino.sv
// Directed bench for the GPR/SPR arbiter. A small behavioural GPR RAM sits
// on the RAM ports; expected read responses are queued at issue time and a
// monitor compares them whenever ack pulses.
module tb_mor1kx_rf_spr_arbiter_cappuccino;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   spr_bus_addr_i;
  logic          spr_bus_stb_i;
  logic          spr_bus_we_i;
  logic [DW-1:0] spr_bus_dat_i;
  logic          spr_gpr_ack_o;
  logic [DW-1:0] spr_gpr_dat_o;
  logic          padv_ctrl_i;
  logic          wb_rf_wb_i;
  logic [AW-1:0] wb_rfd_adr_i;
  logic [DW-1:0] result_i;
  logic          rf_wren_o;
  logic [AW-1:0] rf_wradr_o;
  logic [DW-1:0] rf_wrdat_o;
  logic          rf_re_o;
  logic [AW-1:0] rf_rdad_o;
  logic [DW-1:0] rf_rdat_i;
  logic          spr_stall_o;

  // clock / reset
  always #5 clk = ~clk;

  mor1kx_rf_spr_arbiter_cappuccino dut (
    .clk            (clk),
    .rst            (rst),
    .spr_bus_addr_i (spr_bus_addr_i),
    .spr_bus_stb_i  (spr_bus_stb_i),
    .spr_bus_we_i   (spr_bus_we_i),
    .spr_bus_dat_i  (spr_bus_dat_i),
    .spr_gpr_ack_o  (spr_gpr_ack_o),
    .spr_gpr_dat_o  (spr_gpr_dat_o),
    .padv_ctrl_i    (padv_ctrl_i),
    .wb_rf_wb_i     (wb_rf_wb_i),
    .wb_rfd_adr_i   (wb_rfd_adr_i),
    .result_i       (result_i),
    .rf_wren_o      (rf_wren_o),
    .rf_wradr_o     (rf_wradr_o),
    .rf_wrdat_o     (rf_wrdat_o),
    .rf_re_o        (rf_re_o),
    .rf_rdad_o      (rf_rdad_o),
    .rf_rdat_i      (rf_rdat_i),
    .spr_stall_o    (spr_stall_o)
  );

  // behavioural GPR RAM, read-first, 1-cycle read latency
  logic          ram_init;
  logic [DW-1:0] mem [0:31];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      ram_q <= '0;
    end else begin
      if (rf_wren_o) mem[rf_wradr_o] <= rf_wrdat_o;
      if (rf_re_o)   ram_q <= mem[rf_rdad_o];
    end
  end
  assign rf_rdat_i = ram_q;

  // scoreboard
  logic [DW:0] exp_q [$];   // bit DW: compare read data on ack
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor: every ack consumes one queued expectation
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!rst && spr_gpr_ack_o) begin
      check("ack_pulse_width", 32'(prev_ack), 32'd0);
      if (exp_q.size() == 0) begin
        check("ack_without_request", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        if (e[DW]) check("rd_data", spr_gpr_dat_o, e[DW-1:0]);
      end
    end
    prev_ack = spr_gpr_ack_o;
  end

  // driver tasks
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  task automatic release_bus();
    next_cyc();
    spr_bus_stb_i = 1'b0;
    next_cyc();
  endtask

  // Simple access with idle writeback and padv low; checks ack latency
  task automatic spr_access(input logic [15:0] addr, input logic we, input logic [31:0] wdat,
                            input int lat, input logic chk_dat, input logic [31:0] exp_dat,
                            input string name);
    spr_bus_addr_i = addr;
    spr_bus_we_i   = we;
    spr_bus_dat_i  = wdat;
    spr_bus_stb_i  = 1'b1;
    exp_q.push_back({chk_dat, exp_dat});
    at_sample();
    check({name, "_wren_c0"}, 32'(rf_wren_o), 32'd0);
    for (int k = 1; k <= lat; k++) begin
      next_cyc();
      at_sample();
      check({name, "_ack"}, 32'(spr_gpr_ack_o), 32'(k == lat));
      if (we && lat == 2 && k == 1) begin
        check({name, "_wren"}, 32'(rf_wren_o), 32'd1);
        check({name, "_wradr"}, 32'(rf_wradr_o), 32'(addr[4:0]));
        check({name, "_wrdat"}, rf_wrdat_o, wdat);
      end
      if (we && lat == 1) check({name, "_no_wren"}, 32'(rf_wren_o), 32'd0);
    end
    release_bus();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ram_init = 1'b1;
    spr_bus_addr_i = '0; spr_bus_stb_i = 1'b0; spr_bus_we_i = 1'b0; spr_bus_dat_i = '0;
    padv_ctrl_i = 1'b0; wb_rf_wb_i = 1'b0; wb_rfd_adr_i = '0; result_i = '0;
    repeat (3) next_cyc();
    at_sample();
    check("rst_ack", 32'(spr_gpr_ack_o), 32'd0);
    check("rst_stall", 32'(spr_stall_o), 32'd0);
    check("rst_re", 32'(rf_re_o), 32'd0);
    check("rst_wren", 32'(rf_wren_o), 32'd0);
    check("rst_dat", spr_gpr_dat_o, 32'd0);
    next_cyc();
    rst = 1'b0; ram_init = 1'b0;
    next_cyc();

    // 1: basic write then read back
    spr_access(16'h0403, 1'b1, 32'hDEADBEEF, 2, 1'b0, 32'h0, "t1_wr");
    spr_access(16'h0403, 1'b0, 32'h0, 3, 1'b1, 32'hDEADBEEF, "t1_rd");

    // 2: writeback holds the port for 10 cycles while an SPR write waits
    spr_bus_addr_i = 16'h0404; spr_bus_we_i = 1'b1; spr_bus_dat_i = 32'hCAFEF00D;
    spr_bus_stb_i = 1'b1;
    wb_rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd9; result_i = 32'h11111111;
    exp_q.push_back({1'b0, 32'h0});
    for (int c = 1; c <= 10; c++) begin
      next_cyc();
      at_sample();
      check("t2_stall", 32'(spr_stall_o), 32'(c >= 9));
      check("t2_no_ack", 32'(spr_gpr_ack_o), 32'd0);
      if (c == 5) check("t2_wb_wradr", 32'(rf_wradr_o), 32'd9);
    end
    next_cyc();
    wb_rf_wb_i = 1'b0;
    at_sample();
    check("t2_wren", 32'(rf_wren_o), 32'd1);
    check("t2_wradr", 32'(rf_wradr_o), 32'd4);
    check("t2_wrdat", rf_wrdat_o, 32'hCAFEF00D);
    check("t2_stall_commit", 32'(spr_stall_o), 32'd1);
    next_cyc();
    at_sample();
    check("t2_ack", 32'(spr_gpr_ack_o), 32'd1);
    check("t2_stall_clr", 32'(spr_stall_o), 32'd0);
    release_bus();
    spr_access(16'h0404, 1'b0, 32'h0, 3, 1'b1, 32'hCAFEF00D, "t2_rd4");
    spr_access(16'h0409, 1'b0, 32'h0, 3, 1'b1, 32'h11111111, "t2_rd9");

    // 3: read delayed by padv_ctrl_i high for 4 cycles
    spr_access(16'h0405, 1'b1, 32'h55AA55AA, 2, 1'b0, 32'h0, "t3_wr");
    spr_bus_addr_i = 16'h0405; spr_bus_we_i = 1'b0; spr_bus_stb_i = 1'b1;
    padv_ctrl_i = 1'b1;
    exp_q.push_back({1'b1, 32'h55AA55AA});
    for (int c = 1; c <= 4; c++) begin
      next_cyc();
      at_sample();
      check("t3_re_held", 32'(rf_re_o), 32'd0);
    end
    next_cyc();
    padv_ctrl_i = 1'b0;
    at_sample();
    check("t3_re", 32'(rf_re_o), 32'd1);
    check("t3_rdad", 32'(rf_rdad_o), 32'd5);
    next_cyc();
    at_sample();
    check("t3_ack_early", 32'(spr_gpr_ack_o), 32'd0);
    next_cyc();
    at_sample();
    check("t3_ack", 32'(spr_gpr_ack_o), 32'd1);
    release_bus();

    // 4a: writeback to the read index in the re cycle
    spr_access(16'h0407, 1'b1, 32'h77777777, 2, 1'b0, 32'h0, "t4_wr");
    spr_bus_addr_i = 16'h0407; spr_bus_we_i = 1'b0; spr_bus_stb_i = 1'b1;
    exp_q.push_back({1'b1, 32'h00001234});
    next_cyc();
    wb_rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd7; result_i = 32'h00001234;
    at_sample();
    check("t4_re", 32'(rf_re_o), 32'd1);
    check("t4_wb_wradr", 32'(rf_wradr_o), 32'd7);
    next_cyc();
    wb_rf_wb_i = 1'b0;
    at_sample();
    check("t4_ack_early", 32'(spr_gpr_ack_o), 32'd0);
    next_cyc();
    at_sample();
    check("t4_ack", 32'(spr_gpr_ack_o), 32'd1);
    release_bus();

    // 4b: writeback to the read index in the data cycle
    spr_bus_addr_i = 16'h0408; spr_bus_we_i = 1'b0; spr_bus_stb_i = 1'b1;
    exp_q.push_back({1'b1, 32'h0000ABCD});
    next_cyc();
    next_cyc();
    wb_rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd8; result_i = 32'h0000ABCD;
    next_cyc();
    wb_rf_wb_i = 1'b0;
    at_sample();
    check("t4b_ack", 32'(spr_gpr_ack_o), 32'd1);
    release_bus();

    // 5: out-of-range index (40 >= 32), plus the last valid index
    spr_access(16'h0428, 1'b0, 32'h0, 1, 1'b1, 32'h0, "t5_oor_rd");
    spr_access(16'h0428, 1'b1, 32'h99999999, 1, 1'b0, 32'h0, "t5_oor_wr");
    spr_access(16'h0408, 1'b0, 32'h0, 3, 1'b1, 32'h0000ABCD, "t5_rd8");
    spr_access(16'h041F, 1'b0, 32'h0, 3, 1'b1, 32'h0, "t5_idx31");

    // non-GPR SPR group is ignored
    spr_bus_addr_i = 16'h0803; spr_bus_we_i = 1'b0; spr_bus_stb_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      next_cyc();
      at_sample();
      check("t5_grp_no_re", 32'(rf_re_o), 32'd0);
      check("t5_grp_no_ack", 32'(spr_gpr_ack_o), 32'd0);
    end
    release_bus();

    // 6a: stb dropped while a write is deferred and stalling
    spr_bus_addr_i = 16'h040A; spr_bus_we_i = 1'b1; spr_bus_dat_i = 32'hBAD0BAD0;
    spr_bus_stb_i = 1'b1;
    wb_rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd12; result_i = 32'h0C0C0C0C;
    for (int c = 1; c <= 9; c++) next_cyc();
    at_sample();
    check("t6_stall_set", 32'(spr_stall_o), 32'd1);
    next_cyc();
    spr_bus_stb_i = 1'b0; wb_rf_wb_i = 1'b0;
    at_sample();
    check("t6_abort_no_wren", 32'(rf_wren_o), 32'd0);
    next_cyc();
    at_sample();
    check("t6_abort_stall", 32'(spr_stall_o), 32'd0);
    check("t6_abort_no_ack", 32'(spr_gpr_ack_o), 32'd0);
    next_cyc();
    spr_access(16'h0405, 1'b0, 32'h0, 3, 1'b1, 32'h55AA55AA, "t6_rd5");

    // 6b: reset pulsed while a read waits on padv_ctrl_i
    spr_bus_addr_i = 16'h0405; spr_bus_we_i = 1'b0; spr_bus_stb_i = 1'b1;
    padv_ctrl_i = 1'b1;
    next_cyc();
    next_cyc();
    rst = 1'b1; padv_ctrl_i = 1'b0;
    at_sample();
    check("t6_rst_no_re", 32'(rf_re_o), 32'd0);
    check("t6_rst_no_wren", 32'(rf_wren_o), 32'd0);
    next_cyc();
    rst = 1'b0; spr_bus_stb_i = 1'b0;
    at_sample();
    check("t6_rst_ack", 32'(spr_gpr_ack_o), 32'd0);
    check("t6_rst_stall", 32'(spr_stall_o), 32'd0);
    check("t6_rst_dat", spr_gpr_dat_o, 32'd0);
    next_cyc();
    next_cyc();
    spr_access(16'h040A, 1'b0, 32'h0, 3, 1'b1, 32'h0, "t6_rd10");
    spr_access(16'h0405, 1'b0, 32'h0, 3, 1'b1, 32'h55AA55AA, "t6_rd5_again");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
